axi_decerr_slv: RTL and testbench



---
 rtl/axi_decerr_slv.sv | 193 +++++++++++++++++++
 tb/tb_axi_decerr_slv.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_decerr_slv.sv
// Default AXI4 target for unmapped addresses: accepts every request, drains write data,
// and answers each write and read with DECERR, strictly in order per direction.

module axi_decerr_slv_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Status comes straight from the registered count, so a same-cycle pop
    // on a full FIFO only re-opens ready on the following cycle.
    assign head  = mem[rd_ptr];
    assign full  = (count == FullCnt);
    assign empty = (count == '0);
endmodule

module axi_decerr_slv #(
    parameter int          AxiIdWidth   = 5,
    parameter int          AxiDataWidth = 64,
    parameter logic [63:0] RespData     = 64'hBADC_AB1E_BADC_AB1E,
    parameter int          MaxTrans     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AxiIdWidth-1:0]   aw_id_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [AxiIdWidth-1:0]   b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [AxiIdWidth-1:0]   ar_id_i,
    input  logic [7:0]              ar_len_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [AxiIdWidth-1:0]   r_id_o,
    output logic [AxiDataWidth-1:0] r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o
);
    localparam logic [1:0] DecErr = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_SEND} r_state_e;

    // Handshakes: a transfer happens on any cycle where valid and ready are both
    // high; our ready outputs depend only on registered state, never on valid.

    logic                  aw_full, aw_empty, aw_pop;
    logic [AxiIdWidth-1:0] aw_head;
    w_state_e              w_state, w_next;

    axi_decerr_slv_fifo #(.Width(AxiIdWidth), .Depth(MaxTrans)) u_aw_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (aw_valid_i),
        .pop   (aw_pop),
        .din   (aw_id_i),
        .head  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        aw_pop = 1'b0;
        case (w_state)
            W_IDLE:  if (!aw_empty) w_next = W_DRAIN;
            W_DRAIN: if (w_valid_i && w_last_i) w_next = W_RESP;
            W_RESP: begin
                if (b_ready_i) begin
                    aw_pop = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_ready_o = !aw_full;
    assign w_ready_o  = (w_state == W_DRAIN);
    assign b_valid_o  = (w_state == W_RESP);
    assign b_id_o     = aw_head;
    assign b_resp_o   = DecErr;

    logic                       ar_full, ar_empty, ar_pop;
    logic [AxiIdWidth+8-1:0]    ar_head;
    logic [7:0]                 beat_cnt;
    r_state_e                   r_state, r_next;

    axi_decerr_slv_fifo #(.Width(AxiIdWidth + 8), .Depth(MaxTrans)) u_ar_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (ar_valid_i),
        .pop   (ar_pop),
        .din   ({ar_id_i, ar_len_i}),
        .head  (ar_head),
        .full  (ar_full),
        .empty (ar_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= R_IDLE;
            beat_cnt <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && !ar_empty) begin
                beat_cnt <= ar_head[7:0];
            end else if (r_state == R_SEND && r_ready_i && beat_cnt != 8'd0) begin
                beat_cnt <= beat_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        ar_pop = 1'b0;
        case (r_state)
            R_IDLE: if (!ar_empty) r_next = R_SEND;
            R_SEND: begin
                if (r_ready_i && beat_cnt == 8'd0) begin
                    ar_pop = 1'b1;
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_ready_o = !ar_full;
    assign r_valid_o  = (r_state == R_SEND);
    assign r_id_o     = ar_head[AxiIdWidth+8-1:8];
    assign r_data_o   = AxiDataWidth'(RespData);
    assign r_resp_o   = DecErr;
    assign r_last_o   = (r_state == R_SEND) && (beat_cnt == 8'd0);
endmodule

// File: tb/tb_axi_decerr_slv.sv
// Self-checking bench for axi_decerr_slv: vector tables, corner sequences and
// randomized concurrent traffic against a queue-based response model.

module tb_axi_decerr_slv;
    localparam int IdW = 5;
    localparam int DW  = 64;
    localparam logic [63:0] RESP_DATA = 64'hBADCAB1EBADCAB1E;

    logic           clk, rst;
    logic           aw_valid, aw_ready;
    logic [IdW-1:0] aw_id;
    logic           w_valid, w_ready, w_last;
    logic           b_valid, b_ready;
    logic [IdW-1:0] b_id;
    logic [1:0]     b_resp;
    logic           ar_valid, ar_ready;
    logic [IdW-1:0] ar_id;
    logic [7:0]     ar_len;
    logic           r_valid, r_ready;
    logic [IdW-1:0] r_id;
    logic [DW-1:0]  r_data;
    logic [1:0]     r_resp;
    logic           r_last;

    axi_decerr_slv dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected, expected handshake", name);
    endfunction

    // scoreboard: expected B ids and expected R beats {id, last}
    logic [IdW-1:0] exp_b_q[$];
    logic [IdW:0]   exp_r_q[$];
    int w_acc = 0, b_cnt = 0, r_cnt = 0, r_big_cnt = 0;
    logic b_hold = 1'b0, r_hold = 1'b0;
    logic [IdW-1:0] b_hold_id, r_hold_id;
    logic r_hold_last;

    always @(negedge clk) begin
        if (rst) begin
            exp_b_q.delete();
            exp_r_q.delete();
            b_hold = 1'b0;
            r_hold = 1'b0;
        end else begin
            if (b_hold) begin
                check("b_valid_stable", b_valid, 1'b1);
                check("b_id_stable", b_id, b_hold_id);
            end
            if (r_hold) begin
                check("r_valid_stable", r_valid, 1'b1);
                check("r_id_stable", r_id, r_hold_id);
                check("r_last_stable", r_last, r_hold_last);
            end
            if (w_valid && w_ready) w_acc++;
            if (b_valid && b_ready) begin
                b_cnt++;
                if (exp_b_q.size() == 0) fail_msg("b_unexpected");
                else begin
                    check("b_id", b_id, exp_b_q.pop_front());
                    check("b_resp", b_resp, 2'b11);
                end
            end
            if (r_valid && r_ready) begin
                logic [IdW:0] e;
                r_cnt++;
                if (r_id == 5'd31) r_big_cnt++;
                if (exp_r_q.size() == 0) fail_msg("r_unexpected");
                else begin
                    e = exp_r_q.pop_front();
                    check("r_id", r_id, e[IdW:1]);
                    check("r_last", r_last, e[0]);
                    check("r_data", r_data, RESP_DATA);
                    check("r_resp", r_resp, 2'b11);
                end
            end
            if (aw_valid && aw_ready) exp_b_q.push_back(aw_id);
            if (ar_valid && ar_ready) begin
                for (int k = 0; k <= int'(ar_len); k++) exp_r_q.push_back({ar_id, k == int'(ar_len)});
            end
            b_hold      = b_valid && !b_ready;
            b_hold_id   = b_id;
            r_hold      = r_valid && !r_ready;
            r_hold_id   = r_id;
            r_hold_last = r_last;
        end
    end

    // driver tasks: inputs change at posedge+1, handshakes sampled at negedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [IdW-1:0] id, input int limit);
        bit ok = 0;
        aw_valid = 1'b1;
        aw_id    = id;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (aw_ready) begin ok = 1; break; end
            step();
        end
        step();
        aw_valid = 1'b0;
        if (!ok) fail_msg("aw_hs_timeout");
    endtask

    task automatic send_ar(input logic [IdW-1:0] id, input logic [7:0] len, input int limit);
        bit ok = 0;
        ar_valid = 1'b1;
        ar_id    = id;
        ar_len   = len;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ar_ready) begin ok = 1; break; end
            step();
        end
        step();
        ar_valid = 1'b0;
        if (!ok) fail_msg("ar_hs_timeout");
    endtask

    task automatic send_w(input int n, input int limit);
        for (int b = 0; b < n; b++) begin
            bit ok = 0;
            w_valid = 1'b1;
            w_last  = (b == n - 1);
            for (int i = 0; i < limit; i++) begin
                @(negedge clk);
                if (w_ready) begin ok = 1; break; end
                step();
            end
            step();
            if (!ok) fail_msg("w_hs_timeout");
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_b_q.size() == 0 && exp_r_q.size() == 0 && !b_valid && !r_valid) break;
            step();
        end
        check("drain_b_q", exp_b_q.size(), 0);
        check("drain_r_q", exp_r_q.size(), 0);
    endtask

    typedef struct { logic [IdW-1:0] id; int nbeats; int exp_accepts; } wr_vec_t;
    typedef struct { logic [IdW-1:0] id; logic [7:0] len; int exp_beats; } rd_vec_t;

    wr_vec_t wr_vecs[4];
    rd_vec_t rd_vecs[4];

    initial begin
        int base, rbase, bbase, exp_w, exp_r, threads_done, seen;

        wr_vecs[0] = '{5'd3,  4, 4};
        wr_vecs[1] = '{5'd0,  1, 1};
        wr_vecs[2] = '{5'd31, 7, 7};
        wr_vecs[3] = '{5'd12, 2, 2};
        rd_vecs[0] = '{5'd5,  8'd7,  8};
        rd_vecs[1] = '{5'd1,  8'd0,  1};
        rd_vecs[2] = '{5'd30, 8'd2,  3};
        rd_vecs[3] = '{5'd0,  8'd15, 16};

        rst = 1'b1;
        aw_valid = 0; aw_id = '0; w_valid = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = '0; ar_len = '0; r_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        @(negedge clk);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_r_last", r_last, 0);
        check("rst_b_id", b_id, 0);
        check("rst_r_id", r_id, 0);
        check("rst_b_resp", b_resp, 2'b11);
        check("rst_r_resp", r_resp, 2'b11);
        check("rst_r_data", r_data, RESP_DATA);
        check("rst_aw_ready", aw_ready, 1);
        check("rst_ar_ready", ar_ready, 1);
        step();

        // write vectors: B one cycle after the last W handshake
        b_ready = 1'b1;
        foreach (wr_vecs[v]) begin
            base = w_acc;
            send_aw(wr_vecs[v].id, 50);
            send_w(wr_vecs[v].nbeats, 50);
            @(negedge clk);
            check("b_latency", b_valid, 1);
            check("b_id_vec", b_id, wr_vecs[v].id);
            step();
            check("w_accepts", w_acc - base, wr_vecs[v].exp_accepts);
        end

        // read vectors: first beat at N+2, back-to-back, one idle cycle after
        r_ready = 1'b1;
        foreach (rd_vecs[v]) begin
            rbase = r_cnt;
            send_ar(rd_vecs[v].id, rd_vecs[v].len, 50);
            @(negedge clk);
            check("r_lat_n1", r_valid, 0);
            step();
            for (int b = 0; b < rd_vecs[v].exp_beats; b++) begin
                @(negedge clk);
                check("r_back2back", r_valid, 1);
                step();
            end
            @(negedge clk);
            check("r_idle_after", r_valid, 0);
            step();
            check("r_beats", r_cnt - rbase, rd_vecs[v].exp_beats);
        end

        // back-pressure: four queued ARs fill the FIFO, then drain in order
        r_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_ar(5'(i), 8'd0, 50);
        @(negedge clk);
        check("ar_ready_full", ar_ready, 0);
        step();
        r_ready = 1'b1;
        wait_drain(100);
        @(negedge clk);
        check("ar_ready_after", ar_ready, 1);
        step();

        // randomized concurrent traffic with random back-pressure
        base = w_acc; rbase = r_cnt; bbase = b_cnt; r_big_cnt = 0;
        exp_w = 0; exp_r = 0; threads_done = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int n;
                    n = $urandom_range(1, 6);
                    send_aw(5'($urandom_range(0, 31)), 2000);
                    send_w(n, 2000);
                    exp_w += n;
                end
                threads_done++;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] l;
                    l = (i == 3) ? 8'd255 : 8'($urandom_range(0, 15));
                    send_ar((i == 3) ? 5'd31 : 5'($urandom_range(0, 30)), l, 2000);
                    exp_r += int'(l) + 1;
                end
                threads_done++;
            end
            begin
                while (threads_done < 2) begin
                    step();
                    b_ready = 1'($urandom_range(0, 1));
                    r_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        b_ready = 1'b1;
        r_ready = 1'b1;
        wait_drain(3000);
        check("rand_w_accepts", w_acc - base, exp_w);
        check("rand_r_beats", r_cnt - rbase, exp_r);
        check("rand_b_count", b_cnt - bbase, 10);
        check("rand_big_burst", r_big_cnt, 256);

        // reset during beat 3 of a len=7 burst
        rbase = r_cnt;
        send_ar(5'd6, 8'd7, 50);
        for (int i = 0; i < 50; i++) begin
            if (r_cnt - rbase >= 2) break;
            step();
        end
        check("pre_rst_beats", r_cnt - rbase, 2);
        check("pre_rst_r_valid", r_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_r_valid", r_valid, 0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_aw_ready", aw_ready, 1);
        check("post_rst_ar_ready", ar_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_valid) seen++;
            step();
        end
        check("post_rst_no_stale", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
